// File: rtl/arbiter_rr_n_pkt_if.sv
// Requester/consumer channel bundle for arbiter_rr_n_pkt.
// slave = arbiter side, master = requesters plus downstream consumer.
interface arbiter_rr_n_pkt_if #(
    parameter int DWIDTH = 16,
    parameter int N      = 4
);
    localparam int IDXW = $clog2(N);

    logic              in_valid [N-1:0];
    logic [DWIDTH-1:0] in_data  [N-1:0];
    logic              in_last  [N-1:0];
    logic              in_ready [N-1:0];

    logic              out_valid;
    logic [DWIDTH-1:0] out_data;
    logic              out_last;
    logic [IDXW-1:0]   out_src;
    logic              out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/arbiter_rr_n_pkt.sv
// Packet-locked N-way round-robin arbiter with registered output.
// Define ARBITER_RR_SKID_EN for a two-entry skid output (no out_ready->in_ready path).
module arbiter_rr_n_pkt #(
    parameter  int DWIDTH = 16,
    parameter  int N      = 4,
    localparam int IDXW   = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    arbiter_rr_n_pkt_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic              last;
        logic [IDXW-1:0]   src;
    } beat_t;

    state_t          state, state_nxt;
    logic [IDXW-1:0] last_grant, lock_idx, grant, scan_idx;
    logic            grant_vld, accept_ok, hs;
    beat_t           in_beat, out_beat;
    logic            out_vld;

    // State register and priority/lock bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= IDXW'(N - 1);
            lock_idx   <= '0;
        end else begin
            state <= state_nxt;
            if (hs && in_beat.last)
                last_grant <= grant;
            if (hs && !in_beat.last && state == IDLE)
                lock_idx <= grant;
        end
    end

    always_comb begin
        state_nxt = state;
        if (hs)
            state_nxt = in_beat.last ? IDLE : LOCKED;
    end

    // Scan far-to-near so the requester closest after last_grant wins
    always_comb begin
        grant     = lock_idx;
        grant_vld = 1'b0;
        scan_idx  = '0;
        if (state == LOCKED) begin
            grant_vld = 1'b1;
        end else begin
            for (int k = N; k >= 1; k--) begin
                scan_idx = IDXW'((int'(last_grant) + k) % N);
                if (bus.in_valid[scan_idx]) begin
                    grant     = scan_idx;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    assign hs      = grant_vld && bus.in_valid[grant] && accept_ok && !reset;
    assign in_beat = '{data: bus.in_data[grant], last: bus.in_last[grant], src: grant};

    for (genvar i = 0; i < N; i++) begin : g_rdy
        assign bus.in_ready[i] = grant_vld && (grant == IDXW'(i)) && accept_ok && !reset;
    end

`ifdef ARBITER_RR_SKID_EN
    beat_t skid_beat;
    logic  skid_vld;

    assign accept_ok = !skid_vld;

    // A beat accepted while the output is stalled parks in the skid entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld   <= 1'b0;
            out_beat  <= '0;
            skid_vld  <= 1'b0;
            skid_beat <= '0;
        end else if (skid_vld) begin
            if (bus.out_ready) begin
                out_beat <= skid_beat;
                skid_vld <= 1'b0;
            end
        end else if (hs) begin
            if (out_vld && !bus.out_ready) begin
                skid_beat <= in_beat;
                skid_vld  <= 1'b1;
            end else begin
                out_beat <= in_beat;
                out_vld  <= 1'b1;
            end
        end else if (bus.out_ready) begin
            out_vld <= 1'b0;
        end
    end
`else
    assign accept_ok = !out_vld || bus.out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_vld  <= 1'b0;
            out_beat <= '0;
        end else if (hs) begin
            out_beat <= in_beat;
            out_vld  <= 1'b1;
        end else if (bus.out_ready) begin
            out_vld <= 1'b0;
        end
    end
`endif

    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_beat.data;
    assign bus.out_last  = out_beat.last;
    assign bus.out_src   = out_beat.src;
endmodule

// File: tb/tb_arbiter_rr_n_pkt.sv
// Self-checking bench for arbiter_rr_n_pkt: directed scenarios plus random traffic
// against a queue-based reference model of the arbitration rules.
module tb_arbiter_rr_n_pkt;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int IW = $clog2(N);

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] src;
    } beat_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    arbiter_rr_n_pkt_if #(.DWIDTH(DW), .N(N)) bus ();
    arbiter_rr_n_pkt #(.DWIDTH(DW), .N(N)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [N-1:0]  v, l, rdy;
    logic [DW-1:0] d [N];
    logic          ordy;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.in_valid[i] = v[i];
            bus.in_data[i]  = d[i];
            bus.in_last[i]  = l[i];
            rdy[i]          = bus.in_ready[i];
        end
        bus.out_ready = ordy;
    end

    int    checks = 0, passed = 0;
    int    owner, ptr, hs_w;
    beat_t q[$];
    beat_t got[$];

    // Expected in_ready: round-robin winner from pointer, or the locked owner
    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int g;
        bit ok;
        r = '0;
        g = -1;
        if (reset) return r;
`ifdef ARBITER_RR_SKID_EN
        ok = q.size() < 2;
`else
        ok = (q.size() == 0) || ordy;
`endif
        if (owner >= 0) g = owner;
        else
            for (int k = 1; k <= N; k++)
                if (g < 0 && v[(ptr + k) % N]) g = (ptr + k) % N;
        if (g >= 0 && ok) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic [DW+3:0] exp_out();
        return (q.size() > 0) ? {1'b1, q[0]} : '0;
    endfunction

    function automatic logic [DW+3:0] act_out();
        return bus.out_valid ? {1'b1, bus.out_data, bus.out_last, bus.out_src}
                             : {bus.out_valid, {(DW+3){1'b0}}};
    endfunction

    // Advance one clock and update the reference model; no comparisons here
    task automatic tick();
        logic [N-1:0] er;
        er   = model_ready();
        hs_w = -1;
        for (int i = 0; i < N; i++) if (er[i] && v[i]) hs_w = i;
        if (bus.out_valid === 1'b1 && ordy)
            got.push_back('{bus.out_data, bus.out_last, bus.out_src});
        @(posedge clk);
        if (!reset) begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (hs_w >= 0) begin
                q.push_back('{d[hs_w], l[hs_w], IW'(hs_w)});
                if (l[hs_w]) begin owner = -1; ptr = hs_w; end
                else owner = hs_w;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        v = '0; l = '0; ordy = 1'b1;
        for (int i = 0; i < N; i++) d[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        q.delete(); got.delete();
        owner = -1; ptr = N - 1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        v = '1; l = '1; ordy = 1'b1;
        for (int i = 0; i < N; i++) d[i] = DW'($urandom);
        #1;
        checks++;
        if (rdy !== '0) $display("FAIL reset_ready got=%b exp=0", rdy);
        else passed++;
        @(posedge clk); #1;
        checks++;
        if ({bus.out_valid, bus.out_data, bus.out_last, bus.out_src} !== '0)
            $display("FAIL reset_out got=%b/%h/%b/%0d exp=0", bus.out_valid, bus.out_data, bus.out_last, bus.out_src);
        else passed++;
        do_reset();
    endtask

    task automatic test_two_req();
        int src_seq[4] = '{0, 2, 0, 2};
        int n = 0;
        do_reset();
        v = 4'b0101; l = 4'b0101;
        d[0] = DW'($urandom); d[2] = DW'($urandom);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (rdy !== model_ready()) $display("FAIL two_req_ready c=%0d got=%b exp=%b", c, rdy, model_ready());
            else passed++;
            tick();
            if (hs_w >= 0) d[hs_w] = DW'($urandom);
            checks++;
            if (act_out() !== exp_out()) $display("FAIL two_req_out c=%0d got=%h exp=%h", c, act_out(), exp_out());
            else passed++;
            checks++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_src) != src_seq[n])
                $display("FAIL two_req_src c=%0d got=%b/%0d exp=1/%0d", c, bus.out_valid, bus.out_src, src_seq[n]);
            else passed++;
            n++;
        end
    endtask

    task automatic test_rotate();
        do_reset();
        v = '1; l = '1;
        for (int i = 0; i < N; i++) d[i] = DW'($urandom);
        for (int c = 0; c < 9; c++) begin
            #1;
            tick();
            if (hs_w >= 0) d[hs_w] = DW'($urandom);
            checks++;
            if (act_out() !== exp_out()) $display("FAIL rotate_out c=%0d got=%h exp=%h", c, act_out(), exp_out());
            else passed++;
            checks++;
            if (bus.out_valid !== 1'b1 || int'(bus.out_src) != c % N)
                $display("FAIL rotate_src c=%0d got=%b/%0d exp=1/%0d", c, bus.out_valid, bus.out_src, c % N);
            else passed++;
        end
    endtask

    task automatic test_locked();
        int sent = 0;
        bit gap_done = 0;
        logic [IW:0] seq[$];
        logic [IW:0] exp_seq[4] = '{{IW'(1), 1'b0}, {IW'(1), 1'b0}, {IW'(1), 1'b1}, {IW'(3), 1'b1}};
        do_reset();
        v[3] = 1'b1; l[3] = 1'b1; d[3] = 16'h0333;
        for (int c = 0; c < 10; c++) begin
            if (sent == 2 && !gap_done) begin v[1] = 1'b0; gap_done = 1; end
            else v[1] = (sent < 3);
            d[1] = 16'h0101 + DW'(sent);
            l[1] = (sent == 2);
            #1;
            checks++;
            if (rdy !== model_ready()) $display("FAIL locked_ready c=%0d got=%b exp=%b", c, rdy, model_ready());
            else passed++;
            if (owner == 1) begin
                checks++;
                if (rdy[3] !== 1'b0) $display("FAIL locked_stall3 c=%0d got=%b exp=0", c, rdy[3]);
                else passed++;
            end
            tick();
            if (hs_w == 1) sent++;
            if (hs_w == 3) v[3] = 1'b0;
            checks++;
            if (act_out() !== exp_out()) $display("FAIL locked_out c=%0d got=%h exp=%h", c, act_out(), exp_out());
            else passed++;
            if (bus.out_valid === 1'b1) seq.push_back({bus.out_src, bus.out_last});
        end
        checks++;
        if (seq.size() != 4) $display("FAIL locked_count got=%0d exp=4", seq.size());
        else begin
            passed++;
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (seq[k] !== exp_seq[k]) $display("FAIL locked_seq k=%0d got=%b exp=%b", k, seq[k], exp_seq[k]);
                else passed++;
            end
        end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        bit pat[5] = '{1, 0, 0, 1, 1};
        logic r0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            ordy = (c < 5) ? pat[c] : 1'b1;
            v[0] = (sent < 3);
            d[0] = 16'h000A + DW'(sent);
            l[0] = (sent == 2);
            #1;
            checks++;
            if (rdy !== model_ready()) $display("FAIL bp_ready c=%0d got=%b exp=%b", c, rdy, model_ready());
            else passed++;
`ifdef ARBITER_RR_SKID_EN
            r0 = rdy[0];
            ordy = ~ordy;
            #1;
            checks++;
            if (rdy[0] !== r0) $display("FAIL bp_skid_comb c=%0d got=%b exp=%b", c, rdy[0], r0);
            else passed++;
            ordy = ~ordy;
            #1;
`else
            r0 = 1'b0;
`endif
            tick();
            if (hs_w == 0) sent++;
            checks++;
            if (act_out() !== exp_out()) $display("FAIL bp_out c=%0d got=%h exp=%h r0=%b", c, act_out(), exp_out(), r0);
            else passed++;
        end
        checks++;
        if (got.size() != 3) $display("FAIL bp_count got=%0d exp=3", got.size());
        else begin
            passed++;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (got[k].data !== 16'h000A + DW'(k) || got[k].src !== '0)
                    $display("FAIL bp_order k=%0d got=%h exp=%h", k, got[k].data, 16'h000A + DW'(k));
                else passed++;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ordy = 1'b0;
        v[1] = 1'b1; l[1] = 1'b0; d[1] = 16'hBEEF;
        #1;
        tick();
        d[1] = 16'hBEF0;
        checks++;
        if (act_out() !== exp_out()) $display("FAIL rmid_pre got=%h exp=%h", act_out(), exp_out());
        else passed++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || rdy !== '0)
            $display("FAIL rmid_async got=%b/%b exp=0/0", bus.out_valid, rdy);
        else passed++;
        @(posedge clk); #1;
        q.delete(); owner = -1; ptr = N - 1;
        reset = 1'b0;
        ordy = 1'b1;
        v = 4'b0101; l = 4'b0101; d[0] = 16'h1000; d[2] = 16'h1002;
        #1;
        checks++;
        if (rdy !== 4'b0001) $display("FAIL rmid_ready got=%b exp=0001", rdy);
        else passed++;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_src !== IW'(0) || act_out() !== exp_out())
            $display("FAIL rmid_first got=%b/%0d exp=1/0", bus.out_valid, bus.out_src);
        else passed++;
    endtask

    task automatic test_random();
        int rem[N];
        do_reset();
        for (int i = 0; i < N; i++) rem[i] = 0;
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && ($urandom % 3 == 0)) begin
                    if (rem[i] == 0) rem[i] = $urandom_range(1, 3);
                    v[i] = 1'b1;
                    d[i] = DW'($urandom);
                    l[i] = (rem[i] == 1);
                end
            end
            ordy = ($urandom % 4 != 0);
            #1;
            checks++;
            if (rdy !== model_ready()) $display("FAIL rand_ready c=%0d got=%b exp=%b", c, rdy, model_ready());
            else passed++;
            tick();
            if (hs_w >= 0) begin
                rem[hs_w]--;
                v[hs_w] = 1'b0;
            end
            checks++;
            if (act_out() !== exp_out()) $display("FAIL rand_out c=%0d got=%h exp=%h", c, act_out(), exp_out());
            else passed++;
        end
    endtask

    initial begin
        owner = -1; ptr = N - 1; hs_w = -1;
        test_reset();
        test_two_req();
        test_rotate();
        test_locked();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/arbiter_rr_n_pkt.md
# arbiter_rr_n_pkt

Packet-aware N-way round-robin arbiter with a registered output stage. It shares one downstream valid/ready channel between N requesters. A grant is locked to one requester from its first accepted beat until its `in_last` beat, so multi-beat transfers are never interleaved. It sits in front of shared engine and memory ports, wherever several cores or FIFOs contend for a single consumer.

## Interface
- `DWIDTH`, 16: payload width in bits.
- `N`, 4: number of requesters; N ≥ 2.
- `IDXW`, `$clog2(N)`: width of the source index (derived, not overridden).

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `in_valid[N-1:0]` in 1 each: requester valid (unpacked array).
- `in_data[N-1:0]` in DWIDTH each: requester payload.
- `in_last[N-1:0]` in 1 each: final beat of the requester's packet.
- `in_ready[N-1:0]` out 1 each: beat accepted when `in_valid[i] && in_ready[i]`.
- `out_valid` out 1: output beat valid.
- `out_data` out DWIDTH: output payload.
- `out_last` out 1: copy of the accepted beat's `in_last`.
- `out_src` out IDXW: index of the requester that supplied the beat.
- `out_ready` in 1: downstream accept.

## Operation
- State machine:
  - IDLE: no packet in progress.
  - LOCKED: packet from `lock_idx` in progress.
- Priority pointer `last_grant`; reset value N-1, so requester 0 has highest priority after reset.
- IDLE grant: the first `i` with `in_valid[i]=1`, scanning from `last_grant+1` upward mod N.
  - The grant is combinational. It may change between cycles until a handshake occurs.
- LOCKED grant: always `lock_idx`. Other requesters are stalled even if `lock_idx` is not valid.
- `in_ready[i] = (i == grant) && accept_ok && !reset`. At most one `in_ready` is high per cycle. `in_ready` is 0 everywhere when no requester is valid in IDLE.
- On a handshake by requester `w`:
  - `in_last=1` (from IDLE or LOCKED): go to IDLE, set `last_grant <= w`.
  - `in_last=0` from IDLE: go to LOCKED, set `lock_idx <= w`. `last_grant` is unchanged.
  - `in_last=0` in LOCKED: stay in LOCKED.
- A single-beat packet (`in_last=1` on the first beat) never enters LOCKED.
- Accepted beats are stored with `{data, last, src}` and presented in order on the output. No beat is dropped or duplicated.
- Inputs must hold `in_valid` and `in_data` stable until accepted. Behaviour is undefined if a requester drops `in_valid` before its handshake.

## Timing
- Latency: 1 cycle. A beat accepted at edge k is visible on `out_*` after edge k.
- Throughput: 1 beat/cycle sustained while `out_ready=1`, including across packet boundaries. A new packet can be granted in the cycle after the previous `in_last` handshake.
- Output holds `out_data`, `out_last` and `out_src` stable while `out_valid && !out_ready`.
- Reset values:
  - `out_valid`, `out_last`: 0.
  - `out_data`, `out_src`: 0.
  - State: IDLE, `last_grant` = N-1, `lock_idx` = 0, buffers empty.
- Reset mid-packet: the lock is abandoned and buffered beats are discarded. After reset, arbitration restarts from requester 0.
- Simultaneous handshake on input and output with a full single register: allowed, and gives pass-through at full rate.

## Configuration
- `ARBITER_RR_SKID_EN` undefined:
  - Output stage is a single register.
  - `accept_ok = !out_valid || out_ready`, a combinational path from `out_ready` to `in_ready`.
- `ARBITER_RR_SKID_EN` defined:
  - Output stage is a two-entry skid buffer.
  - `accept_ok` = skid entry empty, driven from registers only, with no `out_ready`→`in_ready` path.
  - When `out_ready` drops, the single in-flight beat goes to the skid entry. `in_ready` falls the next cycle.
  - Latency and throughput are identical to the undefined case.

## Test plan
- Reset, then requester 0 and 2 both valid with 1-beat packets, `out_ready=1` → `out_src` sequence 0,2,0,2; each beat appears 1 cycle after its handshake.
- N=4, all requesters valid continuously with single-beat packets → grants rotate 0,1,2,3,0; `out_valid` high every cycle after the first.
- Requester 1 sends a 3-beat packet (last on beat 3) while requester 3 is valid → output 1,1,1,3. `out_last` is high on the third beat only. `in_ready[3]` stays 0 during the packet, even across a one-cycle gap in `in_valid[1]`.
- Beats 0xA, 0xB, 0xC from requester 0; `out_ready` toggles 1,0,0,1,1 → output 0xA,0xB,0xC in order with no loss and no duplication. With the macro defined, `in_ready[0]` never responds to `out_ready` in the same cycle.
- `reset` asserted asynchronously mid-packet in LOCKED → `out_valid` is 0 immediately. After release, requesters 2 and 0 valid → first `out_src`=0.
